rank_filter_3x3: RTL

//  3x3 rank filter, one output pixel per clock, CHANNELS independent colour planes per beat.
//  Run-time mode selects median, minimum (erode), maximum (dilate) or bypass.

---
 rtl/rank_filter_3x3_pkg.sv | 35 +++
 rtl/rank_filter_3x3_sort3.sv | 59 +++++
 rtl/rank_filter_3x3.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rank_filter_3x3_pkg.sv
// ---------------------------------------------------------------------------
// rank_filter_3x3_pkg
// Shared definitions for the 3x3 rank filter: mode encodings, pipeline
// latency, and the frame/line marker bundle that travels with every beat.
// ---------------------------------------------------------------------------
package rank_filter_3x3_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MEDIAN = 2'd0;
  localparam mode_t MODE_MIN    = 2'd1;
  localparam mode_t MODE_MAX    = 2'd2;
  localparam mode_t MODE_BYPASS = 2'd3;

  localparam int LATENCY = 3;

  // Frame/line sideband flags carried alongside pixel data.
  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } marks_t;

  function automatic marks_t make_marks(input logic sof, input logic eof,
                                        input logic sol, input logic eol);
    marks_t m;
    m.sof = sof;
    m.eof = eof;
    m.sol = sol;
    m.eol = eol;
    return m;
  endfunction

endpackage

// File: rtl/rank_filter_3x3_sort3.sv
// ---------------------------------------------------------------------------
// rank_sort3
// Purely combinational three-input unsigned sorter built as a three-compare
// network. Ties may resolve either way; the output values are identical.
// Ports:
//   a, b, c      in   DATA_WIDTH   values to sort
//   hi, mid, lo  out  DATA_WIDTH   largest, middle and smallest value
// ---------------------------------------------------------------------------
module rank_sort3
  import rank_filter_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] mid,
  output logic [DATA_WIDTH-1:0] lo
);

  logic [DATA_WIDTH-1:0] ab_max;
  logic [DATA_WIDTH-1:0] ab_min;
  logic [DATA_WIDTH-1:0] rest;

  // Order the first pair.
  always_comb begin
    if (a >= b) begin
      ab_max = a;
      ab_min = b;
    end else begin
      ab_max = b;
      ab_min = a;
    end
  end

  // Larger of the pair against c yields the overall maximum; the loser moves on.
  always_comb begin
    if (ab_max >= c) begin
      hi   = ab_max;
      rest = c;
    end else begin
      hi   = c;
      rest = ab_max;
    end
  end

  // The two remaining candidates give middle and minimum.
  always_comb begin
    if (ab_min >= rest) begin
      mid = ab_min;
      lo  = rest;
    end else begin
      mid = rest;
      lo  = ab_min;
    end
  end

endmodule

// File: rtl/rank_filter_3x3.sv
// ---------------------------------------------------------------------------
// rank_filter_3x3
// 3x3 rank filter (median / min / max / bypass), one output pixel per clock,
// CHANNELS independent colour planes per beat. Three register stages:
//   S1 sorts each window column, S2 sorts the HI/MID/LO rows across columns,
//   S3 selects the ranked result for the mode attached to the beat.
// All stages advance together when the output register is free or drained.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   cfg_mode           requested mode, captured on accepted SOF beats
//   in_val/in_rdy      input handshake (in_rdy is combinational)
//   in_data            window, pixel k=3*row+col, channel c at
//                      [((k*CHANNELS)+c)*DATA_WIDTH +: DATA_WIDTH]
//   in_sof/eof/sol/eol input frame/line markers
//   out_val/out_rdy    output handshake
//   out_data           result, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_sof/eof/sol/eol markers aligned with out_data
//   cur_mode           mode of the most recent SOF beat to reach the output
// ---------------------------------------------------------------------------
module rank_filter_3x3
  import rank_filter_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         cfg_mode,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [9*CHANNELS*DATA_WIDTH-1:0]   in_data,
  input  logic                               in_sof,
  input  logic                               in_eof,
  input  logic                               in_sol,
  input  logic                               in_eol,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [CHANNELS*DATA_WIDTH-1:0]     out_data,
  output logic                               out_sof,
  output logic                               out_eof,
  output logic                               out_sol,
  output logic                               out_eol,
  output logic [1:0]                         cur_mode
);

  typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] plane_t;

  logic  en;
  mode_t frame_mode_r;
  mode_t beat_mode;

  // Column sort results feeding S1.
  plane_t [2:0] col_hi;
  plane_t [2:0] col_mid;
  plane_t [2:0] col_lo;
  plane_t       in_ctr;

  // S1 registers.
  logic         s1_val_r;
  marks_t       s1_marks_r;
  mode_t        s1_mode_r;
  plane_t [2:0] s1_hi_r;
  plane_t [2:0] s1_mid_r;
  plane_t [2:0] s1_lo_r;
  plane_t       s1_ctr_r;

  // Row sort results feeding S2 (only the ranks S3 needs are kept).
  plane_t hi_row_max;
  plane_t hi_row_min;
  plane_t mid_row_med;
  plane_t lo_row_max;
  plane_t lo_row_min;
  plane_t unused_hi_row_mid;
  plane_t unused_mid_row_hi;
  plane_t unused_mid_row_lo;
  plane_t unused_lo_row_mid;

  // S2 registers.
  logic   s2_val_r;
  marks_t s2_marks_r;
  mode_t  s2_mode_r;
  plane_t s2_hi_max_r;
  plane_t s2_hi_min_r;
  plane_t s2_mid_med_r;
  plane_t s2_lo_max_r;
  plane_t s2_lo_min_r;
  plane_t s2_ctr_r;

  // S3 selection.
  plane_t med_out;
  plane_t unused_med_hi;
  plane_t unused_med_lo;
  plane_t result;

  // S3 registers.
  logic   s3_val_r;
  marks_t s3_marks_r;
  plane_t s3_data_r;
  mode_t  cur_mode_r;

  // A bubble in S3 (or a consumer taking the beat) lets the whole pipe move.
  assign en     = out_rdy | ~s3_val_r;
  assign in_rdy = en;

  // Mode for the incoming beat: an SOF beat brings its own, others inherit the frame's.
  always_comb begin
    beat_mode = frame_mode_r;
    if (in_sof) begin
      beat_mode = cfg_mode;
    end else begin
      beat_mode = frame_mode_r;
    end
  end

  // Remember the mode of the last accepted SOF so later beats of the frame reuse it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_mode_r <= MODE_MEDIAN;
    end else if (in_val && in_rdy && in_sof) begin
      frame_mode_r <= cfg_mode;
    end
  end

  genvar ch, col;
  generate
    for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
      assign in_ctr[ch] = in_data[((4*CHANNELS)+ch)*DATA_WIDTH +: DATA_WIDTH];

      for (col = 0; col < 3; col++) begin : g_col
        rank_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_col_sort (
          .a   (in_data[(((0+col)*CHANNELS)+ch)*DATA_WIDTH +: DATA_WIDTH]),
          .b   (in_data[(((3+col)*CHANNELS)+ch)*DATA_WIDTH +: DATA_WIDTH]),
          .c   (in_data[(((6+col)*CHANNELS)+ch)*DATA_WIDTH +: DATA_WIDTH]),
          .hi  (col_hi[col][ch]),
          .mid (col_mid[col][ch]),
          .lo  (col_lo[col][ch])
        );
      end

      rank_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_hi_row (
        .a   (s1_hi_r[0][ch]),
        .b   (s1_hi_r[1][ch]),
        .c   (s1_hi_r[2][ch]),
        .hi  (hi_row_max[ch]),
        .mid (unused_hi_row_mid[ch]),
        .lo  (hi_row_min[ch])
      );

      rank_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_mid_row (
        .a   (s1_mid_r[0][ch]),
        .b   (s1_mid_r[1][ch]),
        .c   (s1_mid_r[2][ch]),
        .hi  (unused_mid_row_hi[ch]),
        .mid (mid_row_med[ch]),
        .lo  (unused_mid_row_lo[ch])
      );

      rank_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_lo_row (
        .a   (s1_lo_r[0][ch]),
        .b   (s1_lo_r[1][ch]),
        .c   (s1_lo_r[2][ch]),
        .hi  (lo_row_max[ch]),
        .mid (unused_lo_row_mid[ch]),
        .lo  (lo_row_min[ch])
      );

      // Median of the three candidates that bracket the true middle rank.
      rank_sort3 #(.DATA_WIDTH(DATA_WIDTH)) u_med (
        .a   (s2_hi_min_r[ch]),
        .b   (s2_mid_med_r[ch]),
        .c   (s2_lo_max_r[ch]),
        .hi  (unused_med_hi[ch]),
        .mid (med_out[ch]),
        .lo  (unused_med_lo[ch])
      );
    end
  endgenerate

  // S1: capture column-sorted window, centre pixel, markers and beat mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val_r   <= 1'b0;
      s1_marks_r <= '0;
      s1_mode_r  <= MODE_MEDIAN;
      s1_hi_r    <= '0;
      s1_mid_r   <= '0;
      s1_lo_r    <= '0;
      s1_ctr_r   <= '0;
    end else if (en) begin
      s1_val_r   <= in_val;
      s1_marks_r <= make_marks(in_sof, in_eof, in_sol, in_eol);
      s1_mode_r  <= beat_mode;
      s1_hi_r    <= col_hi;
      s1_mid_r   <= col_mid;
      s1_lo_r    <= col_lo;
      s1_ctr_r   <= in_ctr;
    end
  end

  // S2: keep the row ranks used by the selectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_val_r     <= 1'b0;
      s2_marks_r   <= '0;
      s2_mode_r    <= MODE_MEDIAN;
      s2_hi_max_r  <= '0;
      s2_hi_min_r  <= '0;
      s2_mid_med_r <= '0;
      s2_lo_max_r  <= '0;
      s2_lo_min_r  <= '0;
      s2_ctr_r     <= '0;
    end else if (en) begin
      s2_val_r     <= s1_val_r;
      s2_marks_r   <= s1_marks_r;
      s2_mode_r    <= s1_mode_r;
      s2_hi_max_r  <= hi_row_max;
      s2_hi_min_r  <= hi_row_min;
      s2_mid_med_r <= mid_row_med;
      s2_lo_max_r  <= lo_row_max;
      s2_lo_min_r  <= lo_row_min;
      s2_ctr_r     <= s1_ctr_r;
    end
  end

  // Pick the ranked result for the mode carried by the beat in S2.
  always_comb begin
    result = med_out;
    case (s2_mode_r)
      MODE_MEDIAN: result = med_out;
      MODE_MIN:    result = s2_lo_min_r;
      MODE_MAX:    result = s2_hi_max_r;
      MODE_BYPASS: result = s2_ctr_r;
      default:     result = med_out;
    endcase
  end

  // S3: output register; cur_mode follows SOF beats as they land here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_val_r   <= 1'b0;
      s3_marks_r <= '0;
      s3_data_r  <= '0;
      cur_mode_r <= MODE_MEDIAN;
    end else if (en) begin
      s3_val_r   <= s2_val_r;
      s3_marks_r <= s2_marks_r;
      s3_data_r  <= result;
      if (s2_val_r && s2_marks_r.sof) begin
        cur_mode_r <= s2_mode_r;
      end
    end
  end

  assign out_val  = s3_val_r;
  assign out_data = s3_data_r;
  assign out_sof  = s3_marks_r.sof;
  assign out_eof  = s3_marks_r.eof;
  assign out_sol  = s3_marks_r.sol;
  assign out_eol  = s3_marks_r.eol;
  assign cur_mode = cur_mode_r;

endmodule
